// File: rtl/filt_sample_fifo_pkg.sv
// Shared definitions for the filtered-sample path: the sample type and the
// default buffer depth used by the output FIFO.
package filt_sample_fifo_pkg;

  localparam int SAMPLE_W       = 8;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/filt_sample_fifo_if.sv
// Sample handshake between the FIR stage / register side and the output FIFO.
// The master writes samples and requests pops; the slave (the FIFO) returns
// popped samples with a one-cycle valid pulse.
interface filt_sample_fifo_if #(
  parameter int WIDTH = 8
);

  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    rd_en;
  logic signed [WIDTH-1:0] rd_data;
  logic                    rd_valid;

  modport master (
    output in_valid, in_data, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  in_valid, in_data, rd_en,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/filt_sample_fifo_mem.sv
// Simple dual-port sample storage: one write port, one registered read port.
// The array itself is never reset; only the read register is, so the popped
// sample output starts from a known zero.
module filt_sample_fifo_mem
  import filt_sample_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = SAMPLE_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem_q [DEPTH];
  logic signed [WIDTH-1:0] rdata_q;

  // Write port: plain storage, no reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read port: old contents are read when the same address is written in the
  // same cycle, which is what the full push+pop case relies on.
  always_ff @(posedge clk) begin
    if (reset)   rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/filt_sample_fifo.sv
// Output buffer for filtered samples: circular FIFO with occupancy, threshold
// interrupt and sticky overflow/underflow flags. All status outputs come from
// registers so nothing on the input side reaches an output combinationally.
module filt_sample_fifo
  import filt_sample_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = SAMPLE_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clr,
  filt_sample_fifo_if.slave   bus,
  output logic [AW:0]         count,
  output logic                empty,
  output logic                full,
  input  logic [AW:0]         thresh,
  output logic                thresh_irq,
  output logic                ovf,
  output logic                udf,
  input  logic                flag_clr
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          irq_q, irq_d;
  logic          empty_w, full_w;
  logic          pop_acc, push_acc, ovf_set, udf_set;
  logic          mem_we, mem_re;

  // Accept/reject decisions and next state; clr discards this cycle's traffic.
  always_comb begin
    empty_w    = (count_q == '0);
    full_w     = (count_q == DEPTH_C);
    pop_acc    = bus.rd_en && !empty_w;
    push_acc   = bus.in_valid && enable && (!full_w || pop_acc);
    ovf_set    = bus.in_valid && enable && full_w && !pop_acc;
    udf_set    = bus.rd_en && empty_w;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      mem_we     = push_acc;
      mem_re     = pop_acc;
      rd_valid_d = pop_acc;
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_acc && !pop_acc)      count_d = count_q + 1'b1;
      else if (pop_acc && !push_acc) count_d = count_q - 1'b1;
    end
    // A set event in the same cycle as flag_clr wins.
    ovf_d = ovf_set ? 1'b1 : (flag_clr ? 1'b0 : ovf_q);
    udf_d = udf_set ? 1'b1 : (flag_clr ? 1'b0 : udf_q);
    irq_d = (thresh != '0) && (count_d >= thresh);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      irq_q      <= irq_d;
    end
  end

  filt_sample_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we),
    .waddr(wr_ptr_q),
    .wdata(bus.in_data),
    .re   (mem_re),
    .raddr(rd_ptr_q),
    .rdata(bus.rd_data)
  );

  assign bus.rd_valid = rd_valid_q;
  assign count        = count_q;
  assign empty        = empty_w;
  assign full         = full_w;
  assign thresh_irq   = irq_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

endmodule
